// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder.
package serial_add_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: start/busy/done handshake plus operand and result buses.
interface serial_add_ctrl_if import serial_add_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_add_cell.sv
// serial_add_cell: 1-bit full adder returning {co,s}.
module serial_add_cell (
    input  logic       x,
    input  logic       y,
    input  logic       ci,
    output logic [1:0] cs
);
    assign cs = {1'b0, x} + {1'b0, y} + {1'b0, ci};
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell LSB-first over WIDTH cycles.
module serial_add_ctrl import serial_add_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, sum_sh_q, sum_sh_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]       cs;
    logic             accept;

    serial_add_cell u_cell (.x(a_sh_q[0]), .y(b_sh_q[0]), .ci(carry_q), .cs(cs));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        accept   = (state_q == IDLE || state_q == DONE) && bus.start;
        if (accept) begin
            state_d = RUN;
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (state_q == RUN) begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            sum_sh_d = {cs[0], sum_sh_q[WIDTH-1:1]};
            carry_d  = cs[1];
            cnt_d    = cnt_q + CNT_W'(1);
            // sum/cout are only published here so no partial result is ever visible
            if (cnt_q == LAST) begin
                state_d = DONE;
                sum_d   = sum_sh_d;
                cout_d  = cs[1];
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of the bit-serial adder controller.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;
    logic [W:0] last_res = '0;

    serial_add_ctrl_if #(.WIDTH(W)) bus();
    serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl", 32'(bus.busy & bus.done), 32'd0);
            check("done_pulse", 32'(bus.done & prev_done), 32'd0);
        end
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        prev_done <= bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        tick();
        bus.start = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        bus.cin = 1'($urandom);
    endtask

    task automatic wait_done(input logic [W:0] prev, input int poke);
        int n = 0;
        int bz = 0;
        bit stable = 1'b1;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) bz++;
            if ({bus.cout, bus.sum} !== prev) stable = 1'b0;
            bus.start = (n == poke);
            if (n == poke) begin
                bus.a = 8'hAA;
                bus.b = 8'h55;
            end
            tick();
            n++;
        end
        bus.start = 1'b0;
        check("latency", n, W);
        check("busy_cycles", bz, W);
        check("result_hold", 32'(stable), 32'd1);
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic [W:0] exp, input int poke, input bit idle);
        start_op(a, b, cin);
        check("busy_after_accept", 32'(bus.busy), 32'd1);
        wait_done(last_res, poke);
        check("result", 32'({bus.cout, bus.sum}), 32'(exp));
        last_res = exp;
        if (idle) begin
            tick();
            check("done_clear", 32'(bus.done), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int d0;
        logic [W-1:0] ra, rb;
        logic rc;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", 32'(bus.cout), 32'd0);
        rst = 1'b0;
        tick();

        op(8'h5A, 8'h3C, 1'b0, 9'h096, -1, 1'b1);
        op(8'hFF, 8'h01, 1'b0, 9'h100, -1, 1'b1);
        op(8'hFF, 8'h00, 1'b1, 9'h100, -1, 1'b1);
        op(8'hFF, 8'hFF, 1'b1, 9'h1FF, -1, 1'b1);

        d0 = done_cnt;
        op(8'h10, 8'h20, 1'b0, 9'h030, 3, 1'b1);
        repeat (3) tick();
        check("single_done", done_cnt - d0, 1);

        op(8'h21, 8'h42, 1'b0, 9'h063, -1, 1'b0);
        op(8'h01, 8'h01, 1'b0, 9'h002, -1, 1'b1);

        start_op(8'h77, 8'h11, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_sum", 32'(bus.sum), 32'd0);
        check("abort_cout", 32'(bus.cout), 32'd0);
        last_res = '0;
        d0 = done_cnt;
        repeat (12) tick();
        check("abort_no_done", done_cnt - d0, 0);
        op(8'h03, 8'h04, 1'b0, 9'h007, -1, 1'b1);

        repeat (300) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            op(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc}, -1, 1'($urandom));
        end
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
